// File: rtl/axis_img_pkg.sv
// Shared definitions for the image-stream sink and source: FSM states,
// error-bit positions, header field layout and size limits.
package axis_img_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PIXELS = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int ERR_NO_SOF       = 0;
    localparam int ERR_BAD_HDR      = 1;
    localparam int ERR_EARLY_SOF    = 2;
    localparam int ERR_EOL_MISMATCH = 3;

    localparam int HDR_W_LSB = 0;
    localparam int HDR_W_MSB = 15;
    localparam int HDR_H_LSB = 16;
    localparam int HDR_H_MSB = 31;

    localparam int DEF_MAX_WIDTH  = 4096;
    localparam int DEF_MAX_HEIGHT = 4096;

    // A header is usable when both dimensions are non-zero and within limits.
    function automatic logic hdr_valid(input logic [15:0] w, input logic [15:0] h,
                                       input int max_w, input int max_h);
        return (w != 16'd0) && (h != 16'd0) &&
               (int'({16'd0, w}) <= max_w) && (int'({16'd0, h}) <= max_h);
    endfunction

endpackage

// File: rtl/img_xy_counter.sv
// Column/row position counter for a raster of width x height pixels.
// load restarts at (0,0); step advances one pixel, wrapping col into row.
module img_xy_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             step,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] height,
    output logic             last_col,
    output logic             last_pixel
);

    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;

    assign last_col   = (col == width - CNT_W'(1));
    assign last_pixel = last_col && (row == height - CNT_W'(1));

    // Position register: restart on load, otherwise advance on each step.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            col <= '0;
            row <= '0;
        end else if (load) begin
            col <= '0;
            row <= '0;
        end else if (step) begin
            if (last_col) begin
                col <= '0;
                row <= row + CNT_W'(1);
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/axis_image_sink.sv
// AXI-Stream image sink: checks header/line framing, counts frames and
// reports per-frame completion plus sticky error flags.
// Optional build macro AXIS_IMAGE_SINK_CHECKSUM_EN adds frame_checksum.
module axis_image_sink
    import axis_img_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int MAX_WIDTH          = DEF_MAX_WIDTH,
    parameter int MAX_HEIGHT         = DEF_MAX_HEIGHT,
    parameter int CNT_W              = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          s00_axis_tvalid,
    output logic                          s00_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic [3:0]                    s00_axis_tstrb,
    input  logic                          s00_axis_tlast,
    input  logic                          s00_axis_tuser,
    output logic                          frame_done,
    output logic                          frame_ok,
    output logic [CNT_W-1:0]              frame_width,
    output logic [CNT_W-1:0]              frame_height,
    output logic [CNT_W-1:0]              frame_count,
    output logic [3:0]                    err_status,
    input  logic                          err_clr
`ifdef AXIS_IMAGE_SINK_CHECKSUM_EN
    ,
    output logic [31:0]                   frame_checksum
`endif
);

    state_t      state;
    logic        hs;
    logic        hdr_good;
    logic [15:0] hdr_w;
    logic [15:0] hdr_h;
    logic        load;
    logic        step;
    logic        last_col;
    logic        last_pixel;
    logic        eol_bad;
    logic [3:0]  err_set;
    logic        unused_strb;

    assign unused_strb = ^s00_axis_tstrb;

    assign hs       = s00_axis_tvalid && s00_axis_tready;
    assign hdr_w    = s00_axis_tdata[HDR_W_MSB:HDR_W_LSB];
    assign hdr_h    = s00_axis_tdata[HDR_H_MSB:HDR_H_LSB];
    assign hdr_good = hdr_valid(hdr_w, hdr_h, MAX_WIDTH, MAX_HEIGHT);
    assign eol_bad  = (s00_axis_tlast != last_col);

    // A header beat is honoured in every state that accepts beats.
    assign load = hs && s00_axis_tuser && hdr_good;
    assign step = hs && (state == ST_PIXELS) && !s00_axis_tuser;

    // Error events detected on the current handshake.
    always_comb begin
        err_set                   = '0;
        err_set[ERR_NO_SOF]       = hs && (state == ST_IDLE) && !s00_axis_tuser;
        err_set[ERR_BAD_HDR]      = hs && s00_axis_tuser && !hdr_good;
        err_set[ERR_EARLY_SOF]    = hs && (state == ST_PIXELS) && s00_axis_tuser;
        err_set[ERR_EOL_MISMATCH] = step && eol_bad;
    end

    img_xy_counter #(
        .CNT_W(CNT_W)
    ) u_xy (
        .clk       (clk),
        .resetn    (resetn),
        .load      (load),
        .step      (step),
        .width     (frame_width),
        .height    (frame_height),
        .last_col  (last_col),
        .last_pixel(last_pixel)
    );

    // Framing FSM with registered handshake, status and counter outputs.
    // Every in-frame error ends the frame on the spot, so the frame outcome
    // is fully known at the handshake that closes it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= ST_IDLE;
            s00_axis_tready <= 1'b0;
            frame_done      <= 1'b0;
            frame_ok        <= 1'b0;
            frame_width     <= '0;
            frame_height    <= '0;
            frame_count     <= '0;
            err_status      <= '0;
        end else begin
            s00_axis_tready <= 1'b1;
            frame_done      <= 1'b0;
            frame_ok        <= 1'b0;
            err_status      <= (err_clr ? 4'd0 : err_status) | err_set;
            if (load) begin
                frame_width  <= CNT_W'(hdr_w);
                frame_height <= CNT_W'(hdr_h);
            end
            case (state)
                ST_IDLE, ST_DRAIN: begin
                    if (hs && s00_axis_tuser) begin
                        state <= hdr_good ? ST_PIXELS : ST_IDLE;
                    end
                end
                ST_PIXELS: begin
                    if (hs) begin
                        if (s00_axis_tuser) begin
                            frame_done <= 1'b1;
                            state      <= hdr_good ? ST_PIXELS : ST_IDLE;
                        end else if (eol_bad) begin
                            frame_done <= 1'b1;
                            state      <= ST_DRAIN;
                        end else if (last_pixel) begin
                            frame_done      <= 1'b1;
                            frame_ok        <= 1'b1;
                            frame_count     <= frame_count + CNT_W'(1);
                            s00_axis_tready <= 1'b0;
                            state           <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef AXIS_IMAGE_SINK_CHECKSUM_EN
    // Running pixel sum, restarted by each accepted header and held afterwards.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame_checksum <= '0;
        end else if (load) begin
            frame_checksum <= '0;
        end else if (step) begin
            frame_checksum <= frame_checksum + s00_axis_tdata[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_axis_image_sink.sv
// Scoreboard bench for axis_image_sink: stimulus pushes expected frame
// reports, a negedge monitor pops and compares them on each frame_done.
module tb_axis_image_sink;

    logic        clk = 1'b0;
    logic        resetn;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic        tuser;
    logic        frame_done;
    logic        frame_ok;
    logic [15:0] frame_width;
    logic [15:0] frame_height;
    logic [15:0] frame_count;
    logic [3:0]  err_status;
    logic        err_clr;
`ifdef AXIS_IMAGE_SINK_CHECKSUM_EN
    logic [31:0] frame_checksum;
`endif

    typedef struct {
        logic        ok;
        logic [15:0] count;
        logic [31:0] cks;
        logic        chk_cks;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_count = 16'd0;

    always #5 clk = ~clk;

    axis_image_sink dut (
        .clk            (clk),
        .resetn         (resetn),
        .s00_axis_tvalid(tvalid),
        .s00_axis_tready(tready),
        .s00_axis_tdata (tdata),
        .s00_axis_tstrb (tstrb),
        .s00_axis_tlast (tlast),
        .s00_axis_tuser (tuser),
        .frame_done     (frame_done),
        .frame_ok       (frame_ok),
        .frame_width    (frame_width),
        .frame_height   (frame_height),
        .frame_count    (frame_count),
        .err_status     (err_status),
        .err_clr        (err_clr)
`ifdef AXIS_IMAGE_SINK_CHECKSUM_EN
        ,
        .frame_checksum (frame_checksum)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every frame_done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resetn === 1'b1 && frame_done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame_done actual=1 required=0 at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("frame_ok", {31'd0, frame_ok}, {31'd0, e.ok});
                chk("frame_count", {16'd0, frame_count}, {16'd0, e.count});
`ifdef AXIS_IMAGE_SINK_CHECKSUM_EN
                if (e.chk_cks) chk("frame_checksum", frame_checksum, e.cks);
`endif
            end
        end
    end

    task automatic push(input logic ok, input logic [15:0] cnt, input logic [31:0] cks);
        exp_t e;
        e.ok      = ok;
        e.count   = cnt;
        e.cks     = cks;
        e.chk_cks = ok;
        sb.push_back(e);
    endtask

    // One beat, transferred on the next edge where tready is high.
    task automatic beat(input logic [31:0] d, input logic l, input logic u);
        int n = 0;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        tuser  = u;
        while (tready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (tready !== 1'b1) chk("tready_timeout", {31'd0, tready}, 32'd1);
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raster of pixels base, base+1, ...; tlast on each line end.
    task automatic send_pixels(input int w, input int h, input logic [31:0] base,
                               input logic [31:0] cks);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (r == h - 1 && c == w - 1) begin
                    exp_count++;
                    push(1'b1, exp_count, cks);
                end
                beat(base + 32'(r * w + c), (c == w - 1), 1'b0);
            end
        end
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("err_cleared", {28'd0, err_status}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn  = 1'b0;
        tvalid  = 1'b0;
        tdata   = '0;
        tstrb   = 4'hF;
        tlast   = 1'b0;
        tuser   = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", {31'd0, tready}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_count", {16'd0, frame_count}, 32'd0);
        chk("rst_err", {28'd0, err_status}, 32'd0);
        chk("rst_width", {16'd0, frame_width}, 32'd0);
        resetn = 1'b1;
        idle(1);
        chk("tready_after_rst", {31'd0, tready}, 32'd1);

        // Basic 3x2 frame, pixels 1..6
        beat(32'h0002_0003, 1'b0, 1'b1);
        chk("hdr_width", {16'd0, frame_width}, 32'd3);
        chk("hdr_height", {16'd0, frame_height}, 32'd2);
        send_pixels(3, 2, 32'd1, 32'd21);
        chk("done_bubble_tready", {31'd0, tready}, 32'd0);
        idle(3);
        chk("f1_count", {16'd0, frame_count}, 32'd1);
        chk("f1_err", {28'd0, err_status}, 32'd0);

        // Pixels before any header
        beat(32'd7, 1'b0, 1'b0);
        beat(32'd8, 1'b1, 1'b0);
        idle(1);
        chk("no_sof_err", {28'd0, err_status}, 32'h1);
        beat(32'h0002_0003, 1'b0, 1'b1);
        send_pixels(3, 2, 32'd1, 32'd21);
        idle(3);
        chk("no_sof_sticky", {28'd0, err_status}, 32'h1);
        clear_err();

        // Zero-height header rejected, FSM stays idle
        beat(32'h0000_0004, 1'b0, 1'b1);
        idle(1);
        chk("bad_hdr_err", {28'd0, err_status}, 32'h2);
        chk("bad_hdr_width_kept", {16'd0, frame_width}, 32'd3);
        chk("bad_hdr_tready", {31'd0, tready}, 32'd1);
        beat(32'h0001_0004, 1'b0, 1'b1);
        send_pixels(4, 1, 32'd10, 32'd46);
        idle(3);
        chk("bad_hdr_recover_count", {16'd0, frame_count}, 32'd3);
        clear_err();

        // Width 4 with tlast on pixel 2, then stray beats dropped
        beat(32'h0002_0004, 1'b0, 1'b1);
        beat(32'd1, 1'b0, 1'b0);
        push(1'b0, exp_count, 32'd0);
        beat(32'd2, 1'b1, 1'b0);
        beat(32'd3, 1'b0, 1'b0);
        beat(32'd4, 1'b1, 1'b0);
        idle(2);
        chk("eol_err", {28'd0, err_status}, 32'h8);
        chk("eol_count", {16'd0, frame_count}, 32'd3);
        beat(32'h0002_0002, 1'b0, 1'b1);
        send_pixels(2, 2, 32'd5, 32'd26);
        idle(3);
        clear_err();

        // New header in the middle of a frame
        beat(32'h0002_0003, 1'b0, 1'b1);
        beat(32'd1, 1'b0, 1'b0);
        beat(32'd2, 1'b0, 1'b0);
        push(1'b0, exp_count, 32'd0);
        beat(32'h0001_0002, 1'b0, 1'b1);
        chk("early_sof_width", {16'd0, frame_width}, 32'd2);
        send_pixels(2, 1, 32'd9, 32'd19);
        idle(3);
        chk("early_sof_err", {28'd0, err_status}, 32'h4);
        chk("early_sof_count", {16'd0, frame_count}, 32'd5);

        // One-cycle reset in the middle of a frame
        beat(32'h0002_0003, 1'b0, 1'b1);
        beat(32'd1, 1'b0, 1'b0);
        beat(32'd2, 1'b0, 1'b0);
        resetn = 1'b0;
        idle(1);
        chk("midrst_tready", {31'd0, tready}, 32'd0);
        chk("midrst_count", {16'd0, frame_count}, 32'd0);
        chk("midrst_err", {28'd0, err_status}, 32'd0);
        chk("midrst_width", {16'd0, frame_width}, 32'd0);
        chk("midrst_done", {31'd0, frame_done}, 32'd0);
        resetn    = 1'b1;
        exp_count = 16'd0;
        idle(1);
        beat(32'h0002_0003, 1'b0, 1'b1);
        send_pixels(3, 2, 32'd1, 32'd21);
        idle(3);
        chk("post_rst_count", {16'd0, frame_count}, 32'd1);

        // Oversized height, then err_clr together with a new error
        beat(32'h1001_0001, 1'b0, 1'b1);
        idle(1);
        chk("oversize_hdr_err", {28'd0, err_status}, 32'h2);
        err_clr = 1'b1;
        beat(32'h55, 1'b0, 1'b0);
        err_clr = 1'b0;
        chk("clr_with_new_err", {28'd0, err_status}, 32'h1);
        clear_err();

        idle(5);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
